// File: rtl/sc_utils_pkg.sv
// Shared types and helpers for the stochastic popcount re-serialiser.
// Window FSM states and the estimate counter width rule.
package sc_utils_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // One extra bit so a full window of ones (== WINDOW) fits.
    function automatic int cnt_width(input int window);
        return $clog2(window) + 1;
    endfunction

endpackage

// File: rtl/sum_to_bit_core.sv
// Error-feedback accumulator turning a popcount into a scaled bitstream.
// Exposes the combinational next bit and accept strobe to the window logic.
module sum_to_bit_core #(
    parameter int SUM_W = 8,
    parameter int SCALE = 128
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [SUM_W-1:0] sum,
    output logic             accept,
    output logic             nxt_bit,
    output logic             out_valid,
    output logic             out_bit,
    output logic             ovf
);

    localparam logic [SUM_W:0]   SCALE_S = (SUM_W+1)'(SCALE);
    localparam logic [SUM_W+1:0] SCALE_T = (SUM_W+2)'(SCALE);

    logic [SUM_W:0]   acc;
    logic [SUM_W:0]   acc_nxt;
    logic [SUM_W:0]   sum_ext;
    logic [SUM_W:0]   s_clamp;
    logic [SUM_W+1:0] t;
    logic [SUM_W+1:0] diff;
    logic             over;

    always_comb begin
        sum_ext = {1'b0, sum};
        over    = sum_ext > SCALE_S;
        s_clamp = over ? SCALE_S : sum_ext;
        t       = {1'b0, acc} + {1'b0, s_clamp};
        diff    = t - SCALE_T;
        nxt_bit = t >= SCALE_T;
        acc_nxt = nxt_bit ? diff[SUM_W:0] : t[SUM_W:0];
    end

    assign accept = in_valid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            out_bit   <= in_valid & nxt_bit;
            if (in_valid) begin
                acc <= acc_nxt;
                if (over)
                    ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/popcount_bitstream_accum.sv
// Popcount to stochastic bitstream with a windowed ones-count estimate.
// The core runs freely; the FSM only frames and tallies windows.
module popcount_bitstream_accum
    import sc_utils_pkg::*;
#(
    parameter int SUM_W  = 8,
    parameter int SCALE  = 128,
    parameter int WINDOW = 256,
    parameter int CNT_W  = cnt_width(WINDOW)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [SUM_W-1:0] sum,
    input  logic             start,
    output logic             out_valid,
    output logic             out_bit,
    output logic             busy,
    output logic             est_valid,
    output logic [CNT_W-1:0] est_value,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

    state_e           state;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] ones_cnt;
    logic [CNT_W-1:0] ones_nxt;
    logic             accept;
    logic             nxt_bit;

    sum_to_bit_core #(
        .SUM_W(SUM_W),
        .SCALE(SCALE)
    ) u_core (
        .CLK      (CLK),
        .RST      (RST),
        .in_valid (in_valid),
        .sum      (sum),
        .accept   (accept),
        .nxt_bit  (nxt_bit),
        .out_valid(out_valid),
        .out_bit  (out_bit),
        .ovf      (ovf)
    );

    assign ones_nxt = ones_cnt + CNT_W'(nxt_bit);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            busy       <= 1'b0;
            est_valid  <= 1'b0;
            est_value  <= '0;
            sample_cnt <= '0;
            ones_cnt   <= '0;
        end else begin
            est_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sample_cnt <= '0;
                        ones_cnt   <= '0;
                        state      <= RUN;
                        busy       <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        sample_cnt <= sample_cnt + 1'b1;
                        ones_cnt   <= ones_nxt;
                        // Final sample's bit is folded in directly.
                        if (sample_cnt == LAST) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            est_valid <= 1'b1;
                            est_value <= ones_nxt;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        sample_cnt <= '0;
                        ones_cnt   <= '0;
                        state      <= RUN;
                        busy       <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_bitstream_accum.sv
// Table-driven bench with a scoreboard queue for popcount_bitstream_accum.
module tb_popcount_bitstream_accum;

    localparam int SCALE  = 128;
    localparam int WINDOW = 256;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] sum = '0;
    logic       start = 1'b0;
    logic       out_valid;
    logic       out_bit;
    logic       busy;
    logic       est_valid;
    logic [8:0] est_value;
    logic       ovf;

    popcount_bitstream_accum dut (
        .CLK      (CLK),
        .RST      (RST),
        .in_valid (in_valid),
        .sum      (sum),
        .start    (start),
        .out_valid(out_valid),
        .out_bit  (out_bit),
        .busy     (busy),
        .est_valid(est_valid),
        .est_value(est_value),
        .ovf      (ovf)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int ov;
        int ob;
        int bz;
        int ev;
        int est;
        int of;
    } exp_t;

    typedef struct {
        int sum;
        int est;
    } vec_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    int m_acc = 0;
    int m_state = 0;
    int m_cnt = 0;
    int m_ones = 0;
    int m_est = 0;
    int m_ovf = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int v, input int s, input int st);
        exp_t e;
        int b;
        int sc;
        int t;
        in_valid = v[0];
        sum = 8'(s);
        start = st[0];
        b = 0;
        if (v != 0) begin
            sc = (s > SCALE) ? SCALE : s;
            if (s > SCALE) m_ovf = 1;
            t = m_acc + sc;
            if (t >= SCALE) begin
                b = 1;
                m_acc = t - SCALE;
            end else begin
                m_acc = t;
            end
        end
        case (m_state)
            0: if (st != 0) begin
                m_cnt = 0; m_ones = 0; m_state = 1;
            end
            1: if (v != 0) begin
                m_cnt++;
                m_ones += b;
                if (m_cnt == WINDOW) begin
                    m_est = m_ones;
                    m_state = 2;
                end
            end
            default: if (st != 0) begin
                m_cnt = 0; m_ones = 0; m_state = 1;
            end else begin
                m_state = 0;
            end
        endcase
        e.ov = v;
        e.ob = b;
        e.bz = (m_state == 1) ? 1 : 0;
        e.ev = (m_state == 2) ? 1 : 0;
        e.est = m_est;
        e.of = m_ovf;
        sb.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
        e = sb.pop_front();
        chk("out_valid", int'(out_valid), e.ov);
        chk("out_bit", int'(out_bit), e.ob);
        chk("busy", int'(busy), e.bz);
        chk("est_valid", int'(est_valid), e.ev);
        chk("est_value", int'(est_value), e.est);
        chk("ovf", int'(ovf), e.of);
    endtask

    task automatic do_reset();
        #1;
        RST = 1'b1;
        in_valid = 1'b0;
        start = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_bit", int'(out_bit), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_est_valid", int'(est_valid), 0);
        chk("rst_est_value", int'(est_value), 0);
        chk("rst_ovf", int'(ovf), 0);
        m_acc = 0; m_state = 0; m_cnt = 0;
        m_ones = 0; m_est = 0; m_ovf = 0;
        sb.delete();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{sum: 64,  est: 128};
        vecs[1] = '{sum: 128, est: 256};
        vecs[2] = '{sum: 0,   est: 0};
        vecs[3] = '{sum: 32,  est: 64};

        @(negedge CLK);
        do_reset();

        // Constant-sum windows, each started from an idle gap.
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1);
            for (int i = 0; i < WINDOW + 20; i++) begin
                step(1, vecs[k].sum, 0);
                if (est_valid) break;
            end
            chk($sformatf("win%0d_done", k), int'(est_valid), 1);
            chk($sformatf("win%0d_est", k), int'(est_value), vecs[k].est);
            step(0, 0, 0);
        end

        // Over-range sum clamps to SCALE and latches ovf.
        step(1, 200, 0);
        chk("ovf_bit", int'(out_bit), 1);
        chk("ovf_set", int'(ovf), 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        chk("ovf_sticky", int'(ovf), 1);

        // Gapped input stretches the window.
        step(0, 0, 1);
        for (int i = 0; i < 2 * WINDOW + 20; i++) begin
            step((i % 2 == 0) ? 1 : 0, 64, 0);
            if (est_valid) break;
        end
        chk("gap_done", int'(est_valid), 1);
        chk("gap_est", int'(est_value), 128);

        // start held high: back-to-back windows.
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < WINDOW + 20; i++) begin
                step(1, 128, 1);
                if (est_valid) break;
            end
            chk("held_done", int'(est_valid), 1);
            chk("held_busy_done", int'(busy), 0);
            chk("held_est", int'(est_value), 256);
            step(1, 128, 1);
            chk("held_rerun", int'(busy), 1);
        end
        for (int i = 0; i < 5; i++) step(0, 0, 0);

        // Abort a window part way through.
        step(0, 0, 1);
        for (int i = 0; i < 100; i++) step(1, 64, 0);
        chk("mid_busy", int'(busy), 1);
        do_reset();
        step(1, 64, 0);
        chk("post_rst_b0", int'(out_bit), 0);
        step(1, 64, 0);
        chk("post_rst_b1", int'(out_bit), 1);
        for (int i = 0; i < WINDOW; i++) step(1, 64, 0);
        chk("post_rst_idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/popcount_bitstream_accum.md
Name: popcount_bitstream_accum

Overview:
- Downstream stage of the 1-bit adder trees.
- Takes the per-cycle popcount `sum` (e.g. 8-bit from a 128-input tree) and re-serialises it into a scaled stochastic bitstream: out_bit = 1 on average sum/SCALE of the time.
- Error-feedback accumulator; no RNG needed.
- A windowed counter tallies output ones over WINDOW samples, giving a deterministic estimate for readout and debug.

Parameters:
- SUM_W, 8: width of input popcount.
- SCALE, 128: divisor, equal to number of tree inputs; must be ≥1 and ≤ 2^SUM_W.
- WINDOW, 256: samples per estimate window, ≥2.
- CNT_W, $clog2(WINDOW)+1: width of est_value; holds 0..WINDOW.

Ports:
- CLK  input  1  clock, all state on rising edge.
- RST  input  1  asynchronous, active-high reset.
- in_valid  input  1  sum is valid this cycle.
- sum  input  SUM_W  popcount from adder tree.
- start  input  1  pulse: begin a new estimate window.
- out_valid  output  1  out_bit valid (registered in_valid).
- out_bit  output  1  stochastic output bit.
- busy  output  1  window in progress (state RUN).
- est_valid  output  1  one-cycle pulse, est_value valid.
- est_value  output  CNT_W  count of out_bit ones in last window.
- ovf  output  1  sticky: a sum > SCALE was seen.

Behaviour:
- Interface: one clock CLK; reset RST is asynchronous, active-high.
- Reset values: all outputs 0; accumulator 0; sample counter 0; ones counter 0; state IDLE. RST asserted mid-window aborts the window; no est_valid is produced.
- Accumulator acc has width SUM_W+1 and always satisfies acc < SCALE.
- Per cycle with in_valid=1:
  - s = min(sum, SCALE); if sum > SCALE, ovf <= 1 (sticky until RST).
  - t = acc + s, computed at SUM_W+2 bits (no overflow).
  - If t ≥ SCALE: bit=1, acc <= t − SCALE. Else: bit=0, acc <= t.
- Latency 1: out_valid/out_bit registered at cycle n+1 for a sample at cycle n.
- in_valid=0: acc held; out_valid=0, out_bit=0 next cycle.
- Bitstream generation runs in every state; acc is cleared only by RST.
- FSM states IDLE, RUN, DONE:
  - IDLE: on start=1, clear sample and ones counters, go to RUN. A sample arriving in the same cycle as start is not counted.
  - RUN: each in_valid cycle increments the sample count and adds that sample's bit to the ones count. On the WINDOW-th counted sample, go to DONE. start is ignored in RUN.
  - DONE (1 cycle): est_valid=1; est_value holds the ones count including the last sample. If start=1, clear counters and go to RUN; else go to IDLE. A sample in the DONE cycle is not counted.
- est_value is registered and held until the next window completes; it is zeroed only by RST.
- busy=1 exactly while in RUN.
- est_valid asserts at cycle n+1 after the final sample at cycle n.
- in_valid gaps inside RUN stretch the window; counting resumes on the next valid sample.

Decomposition:
- Shared package sc_utils_pkg:
  - state enum typedef (IDLE/RUN/DONE).
  - helper function for the CNT_W computation.
- One sub-module: sum_to_bit_core, containing the accumulator, clamp, ovf flag and registered out_bit/out_valid.
- Top level holds the FSM and window counters, and consumes the core's combinational next-bit and accept strobe.

Test Plan:
- Reset, then sum=64 constant with in_valid=1, SCALE=128: out_bit sequence 0,1,0,1,… (first out_valid at cycle 1). start pulsed at cycle 0: est_valid pulses one cycle after the 256th counted sample with est_value=128.
- sum=128 constant: out_bit all 1 → est_value=256. sum=0: all 0 → est_value=0. sum=32: pattern 0,0,0,1 repeating → est_value=64.
- sum=200 for one cycle: treated as 128 → out_bit=1, acc unchanged; ovf=1 and stays 1 until RST.
- in_valid toggling 1,0 during RUN with sum=64: est_valid occurs after 256 valid samples (~512 cycles); est_value=128; out_valid mirrors delayed in_valid.
- start held high through DONE: est_valid 1 cycle, busy deasserts only during DONE, next window begins immediately; est_value is stable between pulses.
- RST asserted mid-window (sample 100): outputs zero asynchronously, state IDLE, no est_valid afterward; after release, out_bit restarts from acc=0.
